// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: FSM state type and default parameters shared by seq_signed_multiplier.
package seq_mult_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam int N_DEF = 8;
  localparam int ACC_GUARD_DEF = 4;
endpackage

// File: rtl/seq_signed_multiplier_add_sub_nbit.sv
// add_sub_nbit: width-W adder/subtractor, s = a + b or a - b (modulo 2^W).
module add_sub_nbit #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] s
);
  assign s = sub ? a - b : a + b;
endmodule

// File: rtl/seq_signed_multiplier.sv
// seq_signed_multiplier: radix-2 shift-add two's-complement multiplier, one B bit per cycle.
// Optional product accumulator enabled by defining SEQ_MULT_ACC_EN.
module seq_signed_multiplier
  import seq_mult_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int ACC_GUARD = ACC_GUARD_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N-1:0]             A,
  input  logic [N-1:0]             B,
  output logic                     out_valid,
  input  logic                     out_ready,
`ifdef SEQ_MULT_ACC_EN
  input  logic                     acc_clr,
  output logic [2*N+ACC_GUARD-1:0] acc,
`endif
  output logic [2*N-1:0]           product
);
  localparam int W = 2 * N;
  localparam int CW = $clog2(N) + 1;

  if (N < 2) begin : g_bad_n
    $error("seq_signed_multiplier: N must be >= 2");
  end

  state_t state, next_state;
  logic [W-1:0] a_sh, psum, addend, sum;
  logic [N-1:0] b_sh;
  logic [CW-1:0] cnt;
  logic last, accept, handshake;

  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign accept = in_ready && in_valid;
  assign handshake = out_valid && out_ready;
  assign last = cnt == CW'(N - 1);
  assign addend = b_sh[0] ? a_sh : '0;

  // The MSB of B carries weight -2^(N-1), so its partial product is subtracted.
  add_sub_nbit #(.W(W)) u_add_sub (
    .a  (psum),
    .b  (addend),
    .sub(last),
    .s  (sum)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next_state;

  always_comb
    next_state = state == IDLE ? (in_valid ? CALC : IDLE) :
                 state == CALC ? (last ? DONE : CALC) :
                 (out_ready ? IDLE : DONE);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      psum <= '0;
      cnt <= '0;
      product <= '0;
    end else if (accept) begin
      a_sh <= W'($signed(A));
      b_sh <= B;
      psum <= '0;
      cnt <= '0;
    end else if (state == CALC) begin
      a_sh <= a_sh << 1;
      b_sh <= b_sh >> 1;
      psum <= sum;
      cnt <= cnt + CW'(1);
      if (last) product <= sum;
    end

`ifdef SEQ_MULT_ACC_EN
  localparam int AW = W + ACC_GUARD;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) acc <= '0;
    else if (handshake) acc <= (acc_clr ? '0 : acc) + AW'($signed(product));
    else if (acc_clr) acc <= '0;
`else
  if (ACC_GUARD < 0) begin : g_bad_guard
    $error("seq_signed_multiplier: ACC_GUARD must be >= 0");
  end
`endif
endmodule

// File: tb/tb_seq_signed_multiplier.sv
// tb_seq_signed_multiplier: scoreboard bench for seq_signed_multiplier (N=8), accumulator checks under SEQ_MULT_ACC_EN.
module tb_seq_signed_multiplier;
  localparam int N = 8;

  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [N-1:0] A = '0, B = '0;
  logic in_ready, out_valid;
  logic [2*N-1:0] product;
`ifdef SEQ_MULT_ACC_EN
  logic acc_clr = 1'b0;
  logic [2*N+3:0] acc;
  logic [2*N+3:0] acc_m = '0;
`endif

  int n_vec = 0, n_err = 0, cyc = 0;
  logic [2*N-1:0] sb[$];
  logic [2*N-1:0] last_p = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_signed_multiplier #(.N(N), .ACC_GUARD(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef SEQ_MULT_ACC_EN
    .acc_clr  (acc_clr),
    .acc      (acc),
`endif
    .product  (product)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input int hold,
                        input logic clr, output int t_acc);
    logic signed [2*N-1:0] sa, sbv;
    logic [2*N-1:0] e;
    int t;
    sa = $signed(a);
    sbv = $signed(b);
    sb.push_back(sa * sbv);
    t = 0;
    while (!in_ready && t < 20) begin
      @(posedge clk); #1; t++;
    end
    check("in_ready_before_accept", in_ready, 1);
    out_ready = hold == 0;
    A = a;
    B = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    t_acc = cyc;
    t = 1;
    while (!out_valid && t < 40) begin
      @(posedge clk); #1; t++;
    end
    check("latency", t, N + 1);
    e = sb.pop_front();
    check("product", product, e);
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      in_valid = i[0];
      A = ~a;
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_product", product, e);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
`ifdef SEQ_MULT_ACC_EN
    acc_clr = clr;
`endif
    @(posedge clk); #1;
    out_ready = 1'b0;
`ifdef SEQ_MULT_ACC_EN
    acc_clr = 1'b0;
    acc_m = (clr ? '0 : acc_m) + {{4{e[2*N-1]}}, e};
    check("acc", acc, acc_m);
`endif
    check("idle_after_handshake", {out_valid, in_ready}, 2'b01);
    check("product_held_idle", product, e);
    last_p = e;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got hang expected $finish");
    $fatal(1);
  end

  initial begin
    int t1, t2, seen;
    logic [N-1:0] ra, rb;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_product", product, 0);
`ifdef SEQ_MULT_ACC_EN
    check("rst_acc", acc, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_in_ready", in_ready, 1);

    run_op(8'd3, 8'd5, 0, 1'b1, t1);
    check("p_3x5", product, 16'h000F);
    run_op(8'hFE, 8'd4, 0, 1'b0, t2);
    check("throughput", t2 - t1, N + 2);
`ifdef SEQ_MULT_ACC_EN
    check("acc_is_7", acc, 20'd7);
`endif
    run_op(8'h80, 8'h80, 0, 1'b0, t1);
    check("p_m128xm128", product, 16'h4000);
    run_op(8'h80, 8'h7F, 0, 1'b0, t1);
    check("p_m128x127", product, 16'hC080);
    run_op(8'h7F, 8'hFF, 0, 1'b0, t1);
    check("p_127xm1", product, 16'hFF81);
    run_op(8'h00, 8'h80, 0, 1'b0, t1);
    check("p_0xm128", product, 16'h0000);

    for (int i = 0; i < 6; i++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      run_op(ra, rb, $urandom_range(0, 2), 1'($urandom_range(0, 1)), t1);
    end

    run_op(8'h5A, 8'hC3, 5, 1'b0, t1);

    A = 8'h7B;
    B = 8'h9C;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("calc_product_held", product, last_p);
    check("calc_in_ready", in_ready, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_product", product, 0);
`ifdef SEQ_MULT_ACC_EN
    acc_m = '0;
    check("midrst_acc", acc, 0);
`endif
    #3;
    rst_n = 1'b1;
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      seen += int'(out_valid);
    end
    check("no_valid_after_rst", seen, 0);
    out_ready = 1'b0;

    run_op(8'h81, 8'h02, 1, 1'b0, t1);
`ifdef SEQ_MULT_ACC_EN
    acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    acc_m = '0;
    check("acc_clr_idle", acc, acc_m);
`endif
    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/seq_signed_multiplier.md
SEQ_SIGNED_MULTIPLIER -- requirements
Module: seq_signed_multiplier

Interface
REQ-001 SHALL have parameter N, default 8, meaning operand width in bits; legal range N >= 2.
REQ-002 SHALL have parameter ACC_GUARD, default 4, meaning accumulator guard bits (used only with SEQ_MULT_ACC_EN).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is rising-edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: operands A and B are valid.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-007 SHALL have port A, input, N bits: two's-complement multiplicand.
REQ-008 SHALL have port B, input, N bits: two's-complement multiplier.
REQ-009 SHALL have port out_valid, output, 1 bit: product is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts the product.
REQ-011 SHALL have port product, output, 2N bits: exact two's-complement A*B.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-013 SHALL drive in_ready = 1 only in IDLE.
REQ-014 SHALL accept operands on an edge with in_valid && in_ready: capture A sign-extended to 2N bits, capture B, clear the partial sum and the bit counter, and go to CALC.
REQ-015 SHALL process one B bit per cycle in CALC, LSB first, for exactly N cycles.
REQ-016 For bit i < N-1, SHALL add (A << i) when B[i] = 1.
REQ-017 For bit N-1, SHALL subtract (A << (N-1)) when B[N-1] = 1.
REQ-018 SHALL perform all arithmetic modulo 2^(2N); the result is exact for all inputs, including A = B = -2^(N-1).
REQ-019 SHALL go from CALC to DONE after the Nth bit; latency: an accept at edge k gives out_valid = 1 from cycle k+N+1.
REQ-020 SHALL hold out_valid = 1 and product stable in DONE until out_ready = 1, then return to IDLE on that edge.
REQ-021 SHALL NOT allow a DONE->IDLE edge to also accept new operands; the earliest next accept is the following cycle.
REQ-022 SHALL ignore in_valid outside IDLE, with no effect on state.
REQ-023 SHALL give product X-free: it holds the last completed result in IDLE and CALC (0 after reset).
REQ-024 SHALL sustain a throughput of one product per N+2 cycles with out_ready held high.

Reset
REQ-025 rst_n low SHALL asynchronously force IDLE, in_ready = 1, out_valid = 0, product = 0, partial sum = 0, counter = 0, and accumulator = 0.
REQ-026 Reset asserted mid-CALC or in DONE SHALL discard the operation; no out_valid SHALL follow after release.

Configuration
REQ-027 Macro SEQ_MULT_ACC_EN SHALL, when defined, add input acc_clr (1 bit) and output acc (2N+ACC_GUARD bits).
REQ-028 With SEQ_MULT_ACC_EN, on each DONE handshake the block SHALL set acc <= acc + sign-extended product, or acc <= sign-extended product if acc_clr = 1 on that edge.
REQ-029 With SEQ_MULT_ACC_EN, acc_clr outside a handshake SHALL zero acc; acc SHALL wrap modulo 2^(2N+ACC_GUARD).
REQ-030 Without SEQ_MULT_ACC_EN, the ports acc_clr and acc and the accumulator logic SHALL be absent, and behaviour SHALL otherwise be identical.

Structure
REQ-031 Package seq_mult_pkg SHALL hold the FSM state typedef (IDLE/CALC/DONE) and the default constants for N and ACC_GUARD.
REQ-032 Sub-module add_sub_nbit SHALL provide a parameterised width-W adder/subtractor (inputs a, b, sub; output s); one instance SHALL be used for the per-cycle add/subtract.
REQ-033 The counter width SHALL be $clog2(N)+1.

Verification (N=8)
REQ-034 Bench SHALL check: A=3, B=5, out_ready=1 -> product=0x000F, out_valid exactly 9 cycles after accept.
REQ-035 Bench SHALL check: A=-128, B=-128 -> product=0x4000; A=-128, B=127 -> product=0xC080.
REQ-036 Bench SHALL check: A=127, B=-1 -> product=0xFF81; A=0, B=-128 -> product=0x0000.
REQ-037 Bench SHALL check: out_ready low for 5 cycles in DONE -> out_valid and product held, in_ready=0, in_valid pulses ignored.
REQ-038 Bench SHALL check: rst_n pulsed low in the 4th CALC cycle -> immediate IDLE, in_ready=1, product=0, no out_valid afterwards.
REQ-039 Bench SHALL check, with SEQ_MULT_ACC_EN: 3*5 with acc_clr=1, then -2*4 with acc_clr=0 -> acc=7 after the second handshake.
